// File: rtl/gshare_predictor.sv
// rtl/gshare_predictor.sv - tagged saturating-counter direction predictor, bimodal or gshare indexed
// Fetch lookup is combinational; execute trains the table and repairs the speculative history.
module gshare_predictor #(
  parameter int XLEN      = 32,
  parameter int ENTRIES   = 16,
  parameter int CTR_BITS  = 2,
  parameter int HIST_BITS = 4,
  parameter int TAG_BITS  = 8,
  parameter int GSHARE    = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [XLEN-1:0]      if_pc,
  input  logic                 if_spec_update,
  input  logic                 ex_valid,
  input  logic [XLEN-1:0]      ex_pc,
  input  logic [HIST_BITS-1:0] ex_ghr,
  input  logic                 ex_taken,
  input  logic                 ex_mispredict,
  output logic                 predict_taken,
  output logic                 hit,
  output logic [HIST_BITS-1:0] if_ghr,
  output logic [31:0]          alloc_count,
  output logic [31:0]          mispredict_count
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam logic [CTR_BITS-1:0] CTR_MAX    = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = CTR_BITS'(2 ** (CTR_BITS - 1));
  localparam logic [CTR_BITS-1:0] CTR_WEAK_N = CTR_BITS'(2 ** (CTR_BITS - 1) - 1);

  logic                 r_valid [ENTRIES];
  logic [TAG_BITS-1:0]  r_tag   [ENTRIES];
  logic [CTR_BITS-1:0]  r_ctr   [ENTRIES];
  logic [HIST_BITS-1:0] r_ghr;
  logic [31:0]          r_alloc_count;
  logic [31:0]          r_mispredict_count;

  logic [IDX_BITS-1:0]  w_if_hist;
  logic [IDX_BITS-1:0]  w_ex_hist;
  logic [IDX_BITS-1:0]  w_if_idx;
  logic [IDX_BITS-1:0]  w_ex_idx;
  logic [TAG_BITS-1:0]  w_if_tag;
  logic [TAG_BITS-1:0]  w_ex_tag;
  logic                 w_if_hit;
  logic                 w_ex_hit;
  logic                 w_if_pred;
  logic [HIST_BITS:0]   w_ghr_rec;
  logic [HIST_BITS:0]   w_ghr_spec;
  logic                 w_unused_pc;

  // History is zero-extended into the index width before the XOR; the tag never sees history.
  always_comb begin
    w_if_hist = '0;
    w_ex_hist = '0;
    w_if_hist[HIST_BITS-1:0] = r_ghr;
    w_ex_hist[HIST_BITS-1:0] = ex_ghr;
    w_if_idx = if_pc[IDX_BITS+1:2];
    w_ex_idx = ex_pc[IDX_BITS+1:2];
    if (GSHARE != 0) begin
      w_if_idx = w_if_idx ^ w_if_hist;
      w_ex_idx = w_ex_idx ^ w_ex_hist;
    end
    w_if_tag  = if_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    w_ex_tag  = ex_pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2];
    w_if_hit  = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    w_if_pred = w_if_hit && r_ctr[w_if_idx][CTR_BITS-1];
  end

  // Shift-in via a one-bit-wider concat so HIST_BITS=1 needs no special case.
  assign w_ghr_rec   = {ex_ghr, ex_taken};
  assign w_ghr_spec  = {r_ghr, w_if_pred};
  assign w_unused_pc = ^{if_pc, ex_pc, w_ghr_rec[HIST_BITS], w_ghr_spec[HIST_BITS]};

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
        r_ctr[i]   <= '0;
      end
      r_ghr              <= '0;
      r_alloc_count      <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (ex_valid) begin
        if (w_ex_hit) begin
          if (ex_taken && (r_ctr[w_ex_idx] != CTR_MAX))
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 1'b1;
          else if (!ex_taken && (r_ctr[w_ex_idx] != '0))
            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 1'b1;
        end else begin
          r_valid[w_ex_idx] <= 1'b1;
          r_tag[w_ex_idx]   <= w_ex_tag;
          r_ctr[w_ex_idx]   <= ex_taken ? CTR_WEAK_T : CTR_WEAK_N;
          r_alloc_count     <= r_alloc_count + 32'd1;
        end
      end
      // Mispredict recovery wins over a same-cycle fetch shift.
      if (ex_valid && ex_mispredict) begin
        r_ghr              <= w_ghr_rec[HIST_BITS-1:0];
        r_mispredict_count <= r_mispredict_count + 32'd1;
      end else if (if_spec_update) begin
        r_ghr <= w_ghr_spec[HIST_BITS-1:0];
      end
    end
  end

  assign predict_taken    = w_if_pred;
  assign hit              = w_if_hit;
  assign if_ghr           = r_ghr;
  assign alloc_count      = r_alloc_count;
  assign mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_gshare_predictor.sv
// tb/tb_gshare_predictor.sv - directed bench driving a bimodal and a gshare instance with shared stimulus
module tb_gshare_predictor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] if_pc = '0;
  logic        if_spec_update = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc = '0;
  logic [3:0]  ex_ghr = '0;
  logic        ex_taken = 1'b0;
  logic        ex_mispredict = 1'b0;

  logic        b_pt, b_hit, g_pt, g_hit;
  logic [3:0]  b_ghr, g_ghr;
  logic [31:0] b_alloc, b_mis, g_alloc, g_mis;

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  gshare_predictor #(.GSHARE(0)) dut_b (
    .clock(clock), .reset(reset), .if_pc(if_pc), .if_spec_update(if_spec_update),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ghr(ex_ghr), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .predict_taken(b_pt), .hit(b_hit), .if_ghr(b_ghr),
    .alloc_count(b_alloc), .mispredict_count(b_mis));

  gshare_predictor #(.GSHARE(1)) dut_g (
    .clock(clock), .reset(reset), .if_pc(if_pc), .if_spec_update(if_spec_update),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ghr(ex_ghr), .ex_taken(ex_taken),
    .ex_mispredict(ex_mispredict), .predict_taken(g_pt), .hit(g_hit), .if_ghr(g_ghr),
    .alloc_count(g_alloc), .mispredict_count(g_mis));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    ex_valid = 1'b0;
    ex_mispredict = 1'b0;
    if_spec_update = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic update(input logic [31:0] pc, input logic [3:0] gh, input logic t);
    ex_valid = 1'b1; ex_pc = pc; ex_ghr = gh; ex_taken = t; ex_mispredict = 1'b0;
    tick();
    ex_valid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    if_pc = 32'h100; #1;
    total++; if (b_hit !== 1'b0) begin bad++; $display("FAIL reset_b_hit got=%b exp=0", b_hit); end
    total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL reset_b_pt got=%b exp=0", b_pt); end
    total++; if (b_ghr !== 4'd0) begin bad++; $display("FAIL reset_b_ghr got=%0d exp=0", b_ghr); end
    total++; if (b_alloc !== 32'd0) begin bad++; $display("FAIL reset_b_alloc got=%0d exp=0", b_alloc); end
    total++; if (b_mis !== 32'd0) begin bad++; $display("FAIL reset_b_mis got=%0d exp=0", b_mis); end
    total++; if ({g_hit, g_pt, g_ghr} !== 6'd0) begin bad++; $display("FAIL reset_g_out got=%b exp=0", {g_hit, g_pt, g_ghr}); end
    total++; if ((g_alloc | g_mis) !== 32'd0) begin bad++; $display("FAIL reset_g_cnt got=%0d exp=0", g_alloc | g_mis); end
  endtask

  task automatic test_alloc_bimodal();
    if_pc = 32'h100;
    ex_valid = 1'b1; ex_pc = 32'h100; ex_ghr = 4'd0; ex_taken = 1'b1; #1;
    total++; if (b_hit !== 1'b0) begin bad++; $display("FAIL alloc_same_cycle_hit got=%b exp=0", b_hit); end
    tick(); ex_valid = 1'b0; #1;
    total++; if (b_hit !== 1'b1) begin bad++; $display("FAIL alloc_hit got=%b exp=1", b_hit); end
    total++; if (b_pt !== 1'b1) begin bad++; $display("FAIL alloc_pt got=%b exp=1", b_pt); end
    total++; if (b_alloc !== 32'd1) begin bad++; $display("FAIL alloc_count got=%0d exp=1", b_alloc); end
    update(32'h100, 4'd0, 1'b0);
    total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL train_nt_pt got=%b exp=0", b_pt); end
    total++; if (b_hit !== 1'b1) begin bad++; $display("FAIL train_nt_hit got=%b exp=1", b_hit); end
  endtask

  task automatic test_saturation();
    // ctr 1 -> 2,3,3,3,3; then 3->2 (taken), 2->1 (not taken)
    for (int i = 0; i < 5; i++) update(32'h100, 4'd0, 1'b1);
    total++; if (b_pt !== 1'b1) begin bad++; $display("FAIL sat_high_pt got=%b exp=1", b_pt); end
    update(32'h100, 4'd0, 1'b0);
    total++; if (b_pt !== 1'b1) begin bad++; $display("FAIL sat_dec1_pt got=%b exp=1", b_pt); end
    update(32'h100, 4'd0, 1'b0);
    total++; if (b_pt !== 1'b0) begin bad++; $display("FAIL sat_dec2_pt got=%b exp=0", b_pt); end
    total++; if (b_alloc !== 32'd1) begin bad++; $display("FAIL sat_alloc got=%0d exp=1", b_alloc); end
  endtask

  task automatic test_tag_conflict();
    update(32'h100, 4'd0, 1'b1);
    update(32'h500, 4'd0, 1'b1);
    total++; if (b_alloc !== 32'd2) begin bad++; $display("FAIL conflict_alloc got=%0d exp=2", b_alloc); end
    if_pc = 32'h100; #1;
    total++; if ({b_hit, b_pt} !== 2'b00) begin bad++; $display("FAIL conflict_old got=%b exp=00", {b_hit, b_pt}); end
    if_pc = 32'h500; #1;
    total++; if ({b_hit, b_pt} !== 2'b11) begin bad++; $display("FAIL conflict_new got=%b exp=11", {b_hit, b_pt}); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    ex_valid = 1'b1; ex_ghr = 4'd0; ex_taken = 1'b1; ex_mispredict = 1'b0;
    ex_pc = 32'h100; tick();
    ex_pc = 32'h104; tick();
    ex_pc = 32'h108; ex_taken = 1'b0; tick();
    ex_valid = 1'b0; #1;
    total++; if (b_alloc !== 32'd3) begin bad++; $display("FAIL b2b_alloc got=%0d exp=3", b_alloc); end
    if_pc = 32'h104; #1;
    total++; if ({b_hit, b_pt} !== 2'b11) begin bad++; $display("FAIL b2b_104 got=%b exp=11", {b_hit, b_pt}); end
    if_pc = 32'h108; #1;
    total++; if ({b_hit, b_pt} !== 2'b10) begin bad++; $display("FAIL b2b_108 got=%b exp=10", {b_hit, b_pt}); end
  endtask

  task automatic test_history();
    do_reset();
    // Gshare entries at index 0, 1, 3 so each speculative step predicts taken.
    update(32'h100, 4'd0, 1'b1);
    update(32'h100, 4'd1, 1'b1);
    update(32'h100, 4'd3, 1'b1);
    total++; if (g_alloc !== 32'd3) begin bad++; $display("FAIL hist_g_alloc got=%0d exp=3", g_alloc); end
    total++; if (b_alloc !== 32'd1) begin bad++; $display("FAIL hist_b_alloc got=%0d exp=1", b_alloc); end
    if_pc = 32'h100; if_spec_update = 1'b1;
    tick();
    total++; if (g_ghr !== 4'b0001) begin bad++; $display("FAIL hist_step1 got=%b exp=0001", g_ghr); end
    tick();
    total++; if (g_ghr !== 4'b0011) begin bad++; $display("FAIL hist_step2 got=%b exp=0011", g_ghr); end
    tick();
    total++; if (g_ghr !== 4'b0111) begin bad++; $display("FAIL hist_step3 got=%b exp=0111", g_ghr); end
    ex_valid = 1'b1; ex_mispredict = 1'b1; ex_pc = 32'h100; ex_ghr = 4'b0001; ex_taken = 1'b0;
    tick();
    idle(); #1;
    total++; if (g_ghr !== 4'b0010) begin bad++; $display("FAIL recover_g_ghr got=%b exp=0010", g_ghr); end
    total++; if (g_mis !== 32'd1) begin bad++; $display("FAIL recover_g_mis got=%0d exp=1", g_mis); end
    total++; if (b_ghr !== 4'b0010) begin bad++; $display("FAIL recover_b_ghr got=%b exp=0010", b_ghr); end
  endtask

  task automatic test_gshare_index();
    do_reset();
    update(32'h100, 4'b0011, 1'b1);
    if_pc = 32'h100; #1;
    total++; if (g_hit !== 1'b0) begin bad++; $display("FAIL gidx_g_miss got=%b exp=0", g_hit); end
    total++; if (b_hit !== 1'b1) begin bad++; $display("FAIL gidx_b_hit got=%b exp=1", b_hit); end
    if_pc = 32'h10C; #1;
    total++; if ({g_hit, g_pt} !== 2'b11) begin bad++; $display("FAIL gidx_g_idx3 got=%b exp=11", {g_hit, g_pt}); end
    total++; if (b_hit !== 1'b0) begin bad++; $display("FAIL gidx_b_idx3 got=%b exp=0", b_hit); end
  endtask

  task automatic test_reset_mid_training();
    ex_valid = 1'b1; ex_mispredict = 1'b1; ex_pc = 32'h10C; ex_ghr = 4'b0101; ex_taken = 1'b1;
    if_spec_update = 1'b1; reset = 1'b1;
    tick();
    reset = 1'b0; idle(); if_pc = 32'h10C; #1;
    total++; if ({g_hit, g_pt, g_ghr} !== 6'd0) begin bad++; $display("FAIL rstmid_g_out got=%b exp=0", {g_hit, g_pt, g_ghr}); end
    total++; if (g_alloc !== 32'd0) begin bad++; $display("FAIL rstmid_g_alloc got=%0d exp=0", g_alloc); end
    total++; if (g_mis !== 32'd0) begin bad++; $display("FAIL rstmid_g_mis got=%0d exp=0", g_mis); end
    total++; if ({b_hit, b_pt, b_ghr} !== 6'd0) begin bad++; $display("FAIL rstmid_b_out got=%b exp=0", {b_hit, b_pt, b_ghr}); end
  endtask

  initial begin
    test_reset();
    test_alloc_bimodal();
    test_saturation();
    test_tag_conflict();
    test_back_to_back();
    test_history();
    test_gshare_index();
    test_reset_mid_training();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gshare_predictor.md
# gshare_predictor

Parametrised direction predictor for the fetch stage: a tagged table of saturating counters, indexed by PC alone (bimodal mode) or by PC XOR speculative global history (gshare mode). Fetch reads it combinationally each cycle. Execute trains it with resolved branches and repairs the speculative history on a mispredict. Allocation and mispredict events are counted for performance analysis.

## Interface
- `ENTRIES`, 16: table depth; power of two, ≥ 4. `IDX_BITS` = log2(ENTRIES).
- `CTR_BITS`, 2: saturating counter width, 1..4.
- `HIST_BITS`, 4: global history length, 1..IDX_BITS.
- `TAG_BITS`, 8: stored tag width.
- `GSHARE`, 1: 1 = index XOR history; 0 = bimodal (history still tracked, not used for indexing).
- `clock` in 1: sole clock, all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `if_pc` in `XLEN`: fetch PC to look up.
- `if_spec_update` in 1: fetch commits `predict_taken` into the speculative history this cycle.
- `ex_valid` in 1: a resolved conditional branch is presented this cycle.
- `ex_pc` in `XLEN`: PC of the resolved branch.
- `ex_ghr` in `HIST_BITS`: history snapshot carried with that branch, taken from `if_ghr` at its fetch.
- `ex_taken` in 1: resolved direction.
- `ex_mispredict` in 1: resolved direction differed from the prediction; only meaningful when `ex_valid` is 1.
- `predict_taken` out 1: predicted direction for `if_pc`.
- `hit` out 1: entry is valid and its tag matches.
- `if_ghr` out `HIST_BITS`: current speculative history, to be carried down the pipe.
- `alloc_count` out 32: number of entry allocations, wraps.
- `mispredict_count` out 32: number of `ex_valid & ex_mispredict` events, wraps.

## Operation
- **Entry contents:** valid, tag[TAG_BITS], ctr[CTR_BITS].
- **Index:**
  - Base index is pc[IDX_BITS+1:2].
  - In gshare mode, the index is base XOR the history zero-extended to IDX_BITS.
  - Fetch lookups use `if_ghr`; updates use `ex_ghr`.
- **Tag:** pc[TAG_BITS+IDX_BITS+1:IDX_BITS+2]. The tag is never XORed with history.
- **Lookup (combinational from registered state):**
  - `hit` = valid & tag match.
  - `predict_taken` = hit & ctr[CTR_BITS-1]. A miss predicts not-taken.
- **Update on `ex_valid`:**
  - Hit: ctr increments on taken and decrements on not-taken, saturating at 2^CTR_BITS−1 and 0.
  - Miss (invalid entry or tag mismatch): allocate. Set valid=1 and write the tag. Set ctr to 2^(CTR_BITS−1) if taken, else 2^(CTR_BITS−1)−1. Increment `alloc_count`.
  - With CTR_BITS=1, the counter is set to the taken bit.
- **Speculative history:**
  - If `ex_valid & ex_mispredict`: ghr ← {ex_ghr[HIST_BITS−2:0], ex_taken}. This recovery overrides any fetch update in the same cycle.
  - Else if `if_spec_update`: ghr ← {ghr[HIST_BITS−2:0], predict_taken}.
  - Else ghr holds.
  - With HIST_BITS=1, the new history is the single new bit.
- **Counters:** `mispredict_count` increments on each `ex_valid & ex_mispredict`.
- **Reset:**
  - All valid bits, ctrs and tags are cleared, and ghr, `alloc_count` and `mispredict_count` are cleared.
  - Outputs after reset: `predict_taken`=0, `hit`=0, `if_ghr`=0, both counters 0.
  - Reset dominates any concurrent update, including one arriving mid-training.

## Timing
- Lookup has zero latency: `predict_taken`, `hit` and `if_ghr` are combinational from registered state in the same cycle as `if_pc`.
- A table update takes effect on the next posedge and is visible to lookups in the following cycle.
- A lookup and an update to the same index in the same cycle: the lookup returns the pre-update entry.
- History changes are visible on `if_ghr` the cycle after the edge that applies them.
- No backpressure: an update can be accepted every cycle.

## Test plan
- **Reset, then lookup:** reset, then `if_pc`=0x100 → `hit`=0, `predict_taken`=0, `if_ghr`=0, both counters 0.
- **Allocation and training, bimodal:** GSHARE=0; update 0x100 taken → next cycle `hit`=1, ctr=2, `predict_taken`=1, `alloc_count`=1. Update not-taken → ctr=1, `predict_taken`=0.
- **Saturation:** five taken updates to 0x100 → ctr=3; one not-taken → ctr=2, still `predict_taken`=1; `alloc_count`=1.
- **Tag conflict:** train 0x100, then update 0x500 (same index 0, tag 20 vs 4) → lookup 0x100 gives `hit`=0 and `predict_taken`=0; `alloc_count` increments.
- **History and recovery:** GSHARE=1; three `if_spec_update` cycles with predict 1 → `if_ghr`=0b0111. Then `ex_valid`, `ex_mispredict`, `ex_ghr`=0b0001, `ex_taken`=0, with `if_spec_update` also high → `if_ghr`=0b0010 and `mispredict_count`=1.
- **Gshare indexing, then reset mid-training:** with ghr=0b0011, update 0x100 taken → the entry at index 3 is written, and lookup of 0x100 with ghr=0 misses. Asserting reset with `ex_valid` high clears all outputs the next cycle.
